// File: rtl/led_pkg.sv
// Shared types and constants for the LED frame scheduler.
package led_pkg;

  localparam int unsigned ROWS = 16;
  localparam int unsigned NREQ = 2;

  typedef logic [15:0]       row_t;
  typedef row_t [ROWS-1:0]   frame_t;

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StCommitWait
  } state_t;

endpackage

// File: rtl/led_frame_sched_if.sv
// Row-write bus between frame producers (master) and the frame scheduler (slave).
interface led_frame_sched_if;
  import led_pkg::*;

  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       wr_valid;
  logic [NREQ-1:0]       wr_ready;
  logic [NREQ-1:0][3:0]  wr_row;
  row_t [NREQ-1:0]       wr_red;
  row_t [NREQ-1:0]       wr_grn;
  logic [NREQ-1:0]       wr_last;

  modport master (
    output req, wr_valid, wr_row, wr_red, wr_grn, wr_last,
    input  gnt, wr_ready
  );

  modport slave (
    input  req, wr_valid, wr_row, wr_red, wr_grn, wr_last,
    output gnt, wr_ready
  );

endinterface

// File: rtl/led_req_arb.sv
// Two-requester arbiter: fixed priority (requester 0 wins) by default,
// round-robin with a registered pointer when LED_FRAME_SCHED_RR_EN is defined.
module led_req_arb
  import led_pkg::*;
(
`ifdef LED_FRAME_SCHED_RR_EN
  input  logic            CLK,
  input  logic            RST,
  input  logic            advance,
`endif
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt
);

`ifdef LED_FRAME_SCHED_RR_EN
  // ptr_q names the requester that currently holds priority.
  logic ptr_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr_q <= 1'b0;
    end else if (advance && (|gnt)) begin
      ptr_q <= gnt[0];
    end
  end

  always_comb begin
    gnt = '0;
    if (req[ptr_q]) begin
      gnt[ptr_q] = 1'b1;
    end else if (req[~ptr_q]) begin
      gnt[~ptr_q] = 1'b1;
    end
  end
`else
  always_comb begin
    gnt    = '0;
    gnt[0] = req[0];
    gnt[1] = req[1] & ~req[0];
  end
`endif

endmodule

// File: rtl/led_frame_sched.sv
// Scan-tick divider, shadow row counter and double-buffered bicolour frame with
// arbitrated row writes. Define LED_FRAME_SCHED_RR_EN for round-robin arbitration.
module led_frame_sched
  import led_pkg::*;
#(
  parameter int unsigned FREQDIV = 8,
  parameter int unsigned PERW    = 10
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [PERW-1:0]   period,
  led_frame_sched_if.slave  bus,
  output logic              EnableCount,
  output frame_t            RedPixels,
  output frame_t            GrnPixels,
  output logic              frame_start,
  output logic              swap_pending
);

  localparam int unsigned ScW = FREQDIV + 4;

  logic [PERW-1:0] div_q;
  logic [PERW-1:0] per_q;
  logic            en_q;
  logic [ScW-1:0]  sc_q;
  logic            fs_q;
  logic            boundary;

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] arb_gnt;
  logic [NREQ-1:0] accept;
  logic            swap_q, swap_d;
  logic            wr_en;
  logic            load_front;
  logic            own;
  frame_t          back_red_q, back_grn_q;
  frame_t          front_red_q, front_grn_q;

  // The interval length is latched at each reload so a period change never
  // truncates or stretches the interval already in progress.
  always_ff @(posedge CLK) begin
    if (RST) begin
      div_q <= '0;
      per_q <= period;
      en_q  <= 1'b0;
      sc_q  <= '0;
      fs_q  <= 1'b0;
    end else begin
      if (div_q == per_q) begin
        div_q <= '0;
        per_q <= period;
        en_q  <= 1'b1;
      end else begin
        div_q <= div_q + PERW'(1);
        en_q  <= 1'b0;
      end
      if (en_q) begin
        sc_q <= sc_q + ScW'(1);
      end
      fs_q <= boundary;
    end
  end

  assign boundary = en_q & (&sc_q);

  led_req_arb u_arb (
`ifdef LED_FRAME_SCHED_RR_EN
    .CLK     (CLK),
    .RST     (RST),
    .advance ((state_q == StIdle) && (|bus.req)),
`endif
    .req     (bus.req),
    .gnt     (arb_gnt)
  );

  assign bus.gnt      = gnt_q;
  assign bus.wr_ready = (state_q == StGrant) ? gnt_q : '0;
  assign accept       = bus.wr_valid & bus.wr_ready;
  assign own          = gnt_q[1];

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    swap_d     = swap_q;
    wr_en      = 1'b0;
    load_front = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|bus.req) begin
          gnt_d   = arb_gnt;
          state_d = StGrant;
        end
      end
      StGrant: begin
        wr_en = |accept;
        if (|(accept & bus.wr_last)) begin
          gnt_d   = '0;
          swap_d  = 1'b1;
          state_d = StCommitWait;
        end else if (!(|(bus.req & gnt_q))) begin
          gnt_d   = '0;
          state_d = StIdle;
        end
      end
      StCommitWait: begin
        // The commit edge itself is still StGrant, so only a later boundary swaps.
        if (boundary) begin
          load_front = 1'b1;
          swap_d     = 1'b0;
          state_d    = StIdle;
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      swap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      swap_q  <= swap_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      back_red_q  <= '0;
      back_grn_q  <= '0;
      front_red_q <= '0;
      front_grn_q <= '0;
    end else begin
      if (wr_en) begin
        back_red_q[bus.wr_row[own]] <= bus.wr_red[own];
        back_grn_q[bus.wr_row[own]] <= bus.wr_grn[own];
      end
      if (load_front) begin
        front_red_q <= back_red_q;
        front_grn_q <= back_grn_q;
      end
    end
  end

  assign EnableCount  = en_q;
  assign frame_start  = fs_q;
  assign swap_pending = swap_q;
  assign RedPixels    = front_red_q;
  assign GrnPixels    = front_grn_q;

endmodule

// File: tb/tb_led_frame_sched.sv
// Directed bench for led_frame_sched (FREQDIV=2: 64 scan ticks per frame).
module tb_led_frame_sched;
  import led_pkg::*;

  logic       CLK;
  logic       RST;
  logic [9:0] period;
  logic       EnableCount;
  frame_t     RedPixels;
  frame_t     GrnPixels;
  logic       frame_start;
  logic       swap_pending;

  led_frame_sched_if bus ();

  led_frame_sched #(
    .FREQDIV (2),
    .PERW    (10)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .period       (period),
    .bus          (bus),
    .EnableCount  (EnableCount),
    .RedPixels    (RedPixels),
    .GrnPixels    (GrnPixels),
    .frame_start  (frame_start),
    .swap_pending (swap_pending)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0]  row;
    logic [15:0] red;
    logic [15:0] grn;
    logic        last;
    logic [15:0] exp_red;
    logic [15:0] exp_grn;
  } wr_vec_t;

  wr_vec_t    vecs[5];
  int         checks = 0;
  int         errors = 0;
  frame_t     exp_red, exp_grn;
  logic [1:0] fair_exp[3];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_bus();
    bus.req      = '0;
    bus.wr_valid = '0;
    bus.wr_last  = '0;
    bus.wr_row   = '0;
    bus.wr_red   = '0;
    bus.wr_grn   = '0;
  endtask

  task automatic do_reset(input int n);
    @(negedge CLK);
    clear_bus();
    RST = 1'b1;
    repeat (n) @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic wait_fs(input int budget, output int waited);
    waited = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge CLK);
      if (frame_start) begin
        waited = i;
        break;
      end
    end
  endtask

  task automatic wait_gnt(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (bus.gnt != 2'b00) break;
    end
  endtask

  initial begin
    int   k;
    int   fs_at;
    int   fs_cnt;
    logic pre_ok;
    logic [1:0] seen;

    vecs[0] = '{row: 4'd5,  red: 16'hA5A5, grn: 16'h0000, last: 1'b0,
                exp_red: 16'hA5A5, exp_grn: 16'h0000};
    vecs[1] = '{row: 4'd2,  red: 16'h1234, grn: 16'h4321, last: 1'b0,
                exp_red: 16'hBEEF, exp_grn: 16'h0F0F};
    vecs[2] = '{row: 4'd2,  red: 16'hBEEF, grn: 16'h0F0F, last: 1'b0,
                exp_red: 16'hBEEF, exp_grn: 16'h0F0F};
    vecs[3] = '{row: 4'd9,  red: 16'h0001, grn: 16'h8000, last: 1'b0,
                exp_red: 16'h0001, exp_grn: 16'h8000};
    vecs[4] = '{row: 4'd15, red: 16'hFFFF, grn: 16'h0001, last: 1'b1,
                exp_red: 16'hFFFF, exp_grn: 16'h0001};
`ifdef LED_FRAME_SCHED_RR_EN
    fair_exp[0] = 2'b01; fair_exp[1] = 2'b10; fair_exp[2] = 2'b01;
`else
    fair_exp[0] = 2'b01; fair_exp[1] = 2'b01; fair_exp[2] = 2'b01;
`endif

    // Reset values and divider cadence with period=3.
    RST    = 1'b1;
    period = 10'd3;
    clear_bus();
    repeat (2) @(negedge CLK);
    check("rst_en", EnableCount, 1'b0);
    check("rst_gnt", bus.gnt, 2'b00);
    check("rst_ready", bus.wr_ready, 2'b00);
    check("rst_fs", frame_start, 1'b0);
    check("rst_pending", swap_pending, 1'b0);
    do_reset(2);
    for (int i = 1; i <= 12; i++) begin
      @(negedge CLK);
      check($sformatf("div_c%0d", i), EnableCount, (i % 4) == 0);
    end
    check("rst_red", RedPixels, '0);
    check("rst_grn", GrnPixels, '0);

    // Table-driven frame write and swap; requester 1 scribbles on row 7 meanwhile.
    period = 10'd0;
    do_reset(2);
    bus.req = 2'b01;
    @(negedge CLK);
    check("swap_gnt", bus.gnt, 2'b01);
    check("swap_ready", bus.wr_ready, 2'b01);
    check("en_continuous", EnableCount, 1'b1);
    for (int i = 0; i < 5; i++) begin
      bus.wr_valid  = 2'b11;
      bus.wr_row[0] = vecs[i].row;
      bus.wr_red[0] = vecs[i].red;
      bus.wr_grn[0] = vecs[i].grn;
      bus.wr_last   = {1'b1, vecs[i].last};
      bus.wr_row[1] = 4'd7;
      bus.wr_red[1] = 16'hFFFF;
      bus.wr_grn[1] = 16'hFFFF;
      @(negedge CLK);
    end
    clear_bus();
    k = 6;
    check("commit_gnt", bus.gnt, 2'b00);
    check("commit_ready", bus.wr_ready, 2'b00);
    check("commit_pending", swap_pending, 1'b1);
    pre_ok = 1'b1;
    fs_at  = -1;
    for (int i = 0; i < 100 && fs_at < 0; i++) begin
      @(negedge CLK);
      k++;
      if (frame_start) fs_at = k;
      else if (RedPixels != '0 || GrnPixels != '0) pre_ok = 1'b0;
    end
    check("swap_fs_cycle", fs_at, 65);
    check("pre_swap_zero", pre_ok, 1'b1);
    check("swap_cleared", swap_pending, 1'b0);
    exp_red = '0;
    exp_grn = '0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("swap_red_r%0d", vecs[i].row), RedPixels[vecs[i].row], vecs[i].exp_red);
      check($sformatf("swap_grn_r%0d", vecs[i].row), GrnPixels[vecs[i].row], vecs[i].exp_grn);
      exp_red[vecs[i].row] = vecs[i].exp_red;
      exp_grn[vecs[i].row] = vecs[i].exp_grn;
    end
    check("ignored_red_r7", RedPixels[7], 16'h0000);
    check("ignored_grn_r7", GrnPixels[7], 16'h0000);
    @(negedge CLK);
    check("fs_one_cycle", frame_start, 1'b0);

    // Second frame adds one row on top of the displayed image.
    bus.req = 2'b01;
    wait_gnt(10);
    check("f2_gnt", bus.gnt, 2'b01);
    bus.wr_valid  = 2'b01;
    bus.wr_last   = 2'b01;
    bus.wr_row[0] = 4'd0;
    bus.wr_red[0] = 16'h0F0F;
    bus.wr_grn[0] = 16'hF0F0;
    @(negedge CLK);
    clear_bus();
    wait_fs(100, fs_at);
    exp_red[0] = 16'h0F0F;
    exp_grn[0] = 16'hF0F0;
    check("f2_red", RedPixels, exp_red);
    check("f2_grn", GrnPixels, exp_grn);

    // Abandoned frame from requester 1 never reaches the display.
    bus.req = 2'b10;
    wait_gnt(10);
    check("ab_gnt", bus.gnt, 2'b10);
    for (int i = 0; i < 3; i++) begin
      bus.wr_valid  = 2'b10;
      bus.wr_row[1] = 4'(i * 3 + 1);
      bus.wr_red[1] = 16'hDEAD;
      bus.wr_grn[1] = 16'hCAFE;
      @(negedge CLK);
    end
    clear_bus();
    @(negedge CLK);
    check("ab_gnt_clear", bus.gnt, 2'b00);
    check("ab_pending", swap_pending, 1'b0);
    fs_cnt = 0;
    for (int i = 0; i < 2; i++) begin
      wait_fs(100, fs_at);
      if (fs_at > 0) fs_cnt++;
    end
    check("ab_frames", fs_cnt, 2);
    check("ab_red", RedPixels, exp_red);
    check("ab_grn", GrnPixels, exp_grn);

    // Arbitration fairness with both requesters held high.
    do_reset(2);
    bus.req = 2'b11;
    for (int g = 0; g < 3; g++) begin
      wait_gnt(200);
      check($sformatf("fair_gnt%0d", g), bus.gnt, fair_exp[g]);
      seen          = bus.gnt;
      bus.wr_valid  = seen;
      bus.wr_last   = 2'b11;
      bus.wr_row[0] = 4'd0;
      bus.wr_row[1] = 4'd0;
      @(negedge CLK);
      bus.wr_valid = 2'b00;
      bus.wr_last  = 2'b00;
    end
    clear_bus();

    // Commit on the boundary edge defers the swap by one frame.
    do_reset(2);
    bus.req = 2'b01;
    for (int c = 1; c <= 130; c++) begin
      @(negedge CLK);
      if (c == 64) begin
        bus.wr_valid  = 2'b01;
        bus.wr_last   = 2'b01;
        bus.wr_row[0] = 4'd3;
        bus.wr_red[0] = 16'h3C3C;
        bus.wr_grn[0] = 16'hC3C3;
      end
      if (c == 65) begin
        clear_bus();
        check("coll_fs_wrap", frame_start, 1'b1);
        check("coll_no_swap", RedPixels, '0);
        check("coll_pending", swap_pending, 1'b1);
      end
      if (c == 128) check("coll_hold", RedPixels, '0);
      if (c == 129) begin
        check("coll_fs_swap", frame_start, 1'b1);
        check("coll_red_r3", RedPixels[3], 16'h3C3C);
        check("coll_grn_r3", GrnPixels[3], 16'hC3C3);
        check("coll_pending_clr", swap_pending, 1'b0);
      end
    end

    // Reset during commit wait drops the committed frame.
    do_reset(2);
    bus.req = 2'b01;
    @(negedge CLK);
    bus.wr_valid  = 2'b01;
    bus.wr_last   = 2'b01;
    bus.wr_row[0] = 4'd4;
    bus.wr_red[0] = 16'h1111;
    bus.wr_grn[0] = 16'h2222;
    @(negedge CLK);
    clear_bus();
    check("abort_pending_set", swap_pending, 1'b1);
    repeat (8) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("abort_pending", swap_pending, 1'b0);
    check("abort_gnt", bus.gnt, 2'b00);
    check("abort_en", EnableCount, 1'b0);
    fs_cnt = 0;
    for (int c = 0; c < 140; c++) begin
      @(negedge CLK);
      if (frame_start) fs_cnt++;
    end
    check("abort_frames", fs_cnt, 2);
    check("abort_red", RedPixels, '0);
    check("abort_grn", GrnPixels, '0);
    check("abort_no_pending", swap_pending, 1'b0);
    bus.req = 2'b01;
    @(negedge CLK);
    check("abort_idle_regrant", bus.gnt, 2'b01);
    clear_bus();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_frame_sched.md
LED_FRAME_SCHED -- requirements
Module: led_frame_sched

Interface
REQ-001 SHALL have parameter FREQDIV, default 8, giving the display row dwell as 2^FREQDIV scan ticks; it SHALL match the LED driver's FREQDIV.
REQ-002 SHALL have parameter PERW, default 10, giving the width of the scan-period input.
REQ-003 SHALL have port CLK, input, 1 bit, system clock.
REQ-004 SHALL have port RST, input, 1 bit, reset; RST is synchronous and active-high, and the clock is CLK.
REQ-005 SHALL have port period, input, PERW bits, scan-tick interval minus one, in CLK cycles.
REQ-006 SHALL have port req, input, [1:0], per-requester level request for the back buffer.
REQ-007 SHALL have port gnt, output, [1:0], one-hot-or-zero grant.
REQ-008 SHALL have port wr_valid, input, [1:0], row-write valid per requester.
REQ-009 SHALL have port wr_ready, output, [1:0], row-write ready per requester.
REQ-010 SHALL have port wr_row, input, [1:0][3:0], target row per requester.
REQ-011 SHALL have port wr_red, input, [1:0][15:0], red row data.
REQ-012 SHALL have port wr_grn, input, [1:0][15:0], green row data.
REQ-013 SHALL have port wr_last, input, [1:0], commit-frame flag qualifying wr_valid.
REQ-014 SHALL have port EnableCount, output, 1 bit, scan-tick pulse to the LED driver.
REQ-015 SHALL have port RedPixels, output, [15:0][15:0], front-buffer red.
REQ-016 SHALL have port GrnPixels, output, [15:0][15:0], front-buffer green.
REQ-017 SHALL have port frame_start, output, 1 bit, one-cycle pulse on the cycle the front buffer updates or the frame wraps.
REQ-018 SHALL have port swap_pending, output, 1 bit, high while a committed frame awaits swap.

Function
REQ-019 Divider: EnableCount SHALL pulse for one cycle every period+1 cycles; with period=0, EnableCount SHALL stay high continuously.
REQ-020 A shadow counter of FREQDIV+4 bits SHALL increment on each EnableCount and SHALL mirror the driver's row counter.
REQ-021 A frame boundary SHALL be a cycle with EnableCount=1 and the shadow counter all-ones; frame_start SHALL pulse on the following cycle.
REQ-022 The FSM SHALL have states IDLE, GRANT, COMMIT_WAIT.
REQ-023 IDLE: if any req bit is set, the FSM SHALL grant one requester per the arbitration policy (REQ-034) and go to GRANT the next cycle.
REQ-024 GRANT: wr_ready SHALL equal gnt; an accepted write (wr_valid & wr_ready) SHALL write the back-buffer row wr_row with the red and green data on the same edge.
REQ-025 GRANT: an accepted write with wr_last=1 SHALL write the row, clear gnt, set swap_pending, and go to COMMIT_WAIT.
REQ-026 GRANT: if the owner's req drops without a commit, the FSM SHALL clear gnt and return to IDLE; back-buffer contents SHALL be retained and no swap SHALL occur.
REQ-027 COMMIT_WAIT: wr_ready SHALL be 0. At the first frame boundary strictly after the commit edge, the front buffer SHALL load the back buffer, swap_pending SHALL clear, and the FSM SHALL go to IDLE.
REQ-028 The back buffer SHALL be unchanged by a swap, so a new frame starts from the displayed image.
REQ-029 Writes to the same row in consecutive cycles SHALL resolve last-write-wins; writes from the non-granted requester SHALL be ignored.
REQ-030 A change to period SHALL take effect from the next divider reload, with no spurious pulse.

Reset
REQ-031 While RST=1, the following SHALL be zero: divider, shadow counter, EnableCount, gnt, wr_ready, frame_start, swap_pending, both buffers, and the round-robin pointer; the FSM SHALL be in IDLE.
REQ-032 RST asserted mid-GRANT or mid-COMMIT_WAIT SHALL abort the frame, with no swap.
REQ-033 The first EnableCount after reset release SHALL occur period+1 cycles later.

Configuration
REQ-034 Macro LED_FRAME_SCHED_RR_EN: when defined, arbitration SHALL be round-robin, and the pointer SHALL advance past the last granted requester on each grant. When undefined, requester 0 SHALL have fixed priority and no pointer SHALL be instantiated.

Structure
REQ-035 Shared package led_pkg SHALL hold: typedef row_t (16-bit), frame_t ([15:0][15:0]), an FSM state enum, constant ROWS=16, and constant NREQ=2.
REQ-036 The arbiter SHALL be a sub-module led_req_arb (combinational grant plus optional RR pointer); the divider, FSM, and buffers SHALL remain in the top module.

Verification
REQ-037 Reset test: period=3 and RST held 2 cycles -> EnableCount first high 4 cycles after release, then every 4 cycles; all pixels 0.
REQ-038 Swap timing test: FREQDIV=2, period=0, req[0]=1, write row 5 = 16'hA5A5 red with wr_last -> RedPixels[5] stays 0 until the 64-tick boundary, then equals 16'hA5A5 together with a frame_start pulse.
REQ-039 Fairness test: req=2'b11 held and each owner commits immediately -> gnt sequence 01,10,01 with RR enabled; 01,01,01 with RR disabled.
REQ-040 Abandon test: req[1] granted, 3 rows written, then req[1] dropped -> gnt=0, swap_pending=0, front buffer unchanged after 2 frames.
REQ-041 Boundary collision test: commit on the same edge as a frame boundary -> swap occurs at the next boundary, not the current one.
REQ-042 Abort test: RST pulsed during COMMIT_WAIT -> swap_pending=0, pixels 0, FSM in IDLE.
